// File: rtl/mux2_rr_arbiter.sv
// Round-robin select controller for two valid/ready packet streams feeding a mux2to1.
// Grants are locked per packet, with a registered output stage and a runaway-packet beat limit.
module mux2_rr_arbiter #(
    parameter int W         = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in0_data,
    input  logic         in0_valid,
    input  logic         in0_last,
    output logic         in0_ready,
    input  logic [W-1:0] in1_data,
    input  logic         in1_valid,
    input  logic         in1_last,
    output logic         in1_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         out_last,
    input  logic         out_ready,
    output logic         sel,
    output logic         busy,
    output logic         err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOCK0 = 2'd1;
    localparam logic [1:0] LOCK1 = 2'd2;

    localparam logic [7:0] LAST_IDX = 8'(MAX_BEATS - 1);

    logic [1:0]   state;
    logic         prio;
    logic [7:0]   beat_cnt;
    logic         can_accept;
    logic         xfer;
    logic [W-1:0] xfer_data;
    logic         xfer_last;
    logic         at_limit;
    logic         rel_pkt;

    // The output slot is free when empty or draining this cycle.
    assign can_accept = !out_valid || out_ready;
    assign in0_ready  = (state == LOCK0) && can_accept;
    assign in1_ready  = (state == LOCK1) && can_accept;

    assign xfer      = (in0_valid && in0_ready) || (in1_valid && in1_ready);
    assign xfer_data = (state == LOCK1) ? in1_data : in0_data;
    assign xfer_last = (state == LOCK1) ? in1_last : in0_last;
    assign at_limit  = (beat_cnt == LAST_IDX);
    assign rel_pkt   = xfer && (xfer_last || at_limit);

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            prio      <= 1'b0;
            sel       <= 1'b0;
            beat_cnt  <= 8'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            err       <= 1'b0;
        end else begin
            // A release without the requester's own last marker is a truncation.
            err <= rel_pkt && !xfer_last;

            if (xfer) begin
                out_data  <= xfer_data;
                out_last  <= xfer_last || at_limit;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (in0_valid && (!in1_valid || !prio)) begin
                        state    <= LOCK0;
                        sel      <= 1'b0;
                        beat_cnt <= 8'd0;
                    end else if (in1_valid) begin
                        state    <= LOCK1;
                        sel      <= 1'b1;
                        beat_cnt <= 8'd0;
                    end
                end
                LOCK0, LOCK1: begin
                    if (xfer) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (rel_pkt) begin
                            state <= IDLE;
                            prio  <= (state == LOCK0);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: directed packets with a scoreboard of hand-computed output beats
// and per-cycle checks of grant, ready, busy and truncation signals.
module tb_mux2_rr_arbiter;

    localparam int W         = 8;
    localparam int MAX_BEATS = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] in0_data;
    logic         in0_valid;
    logic         in0_last;
    logic         in0_ready;
    logic [W-1:0] in1_data;
    logic         in1_valid;
    logic         in1_last;
    logic         in1_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_last;
    logic         out_ready;
    logic         sel;
    logic         busy;
    logic         err;

    int total = 0;
    int bad   = 0;
    logic [8:0] sb[$];

    always #5 clk = ~clk;

    mux2_rr_arbiter #(.W(W), .MAX_BEATS(MAX_BEATS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_data  (in0_data),
        .in0_valid (in0_valid),
        .in0_last  (in0_last),
        .in0_ready (in0_ready),
        .in1_data  (in1_data),
        .in1_valid (in1_valid),
        .in1_last  (in1_last),
        .in1_ready (in1_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy),
        .err       (err)
    );

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", name, got, want);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        sb.push_back({l, d});
    endtask

    // Output monitor: every beat the downstream accepts must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [8:0] e;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL out_beat: got=%0h expected=none", {out_last, out_data});
            end else begin
                e = sb.pop_front();
                check_val("out_beat", 32'({out_last, out_data}), 32'(e));
            end
        end
    end

    task automatic applyStimulus(input logic v0, input logic [7:0] d0, input logic l0,
                                 input logic v1, input logic [7:0] d1, input logic l1,
                                 input logic ordy);
        in0_valid = v0; in0_data = d0; in0_last = l0;
        in1_valid = v1; in1_data = d1; in1_last = l1;
        out_ready = ordy;
    endtask

    task automatic checkOutput(input string name, input logic e_busy, input logic e_sel,
                               input logic e_r0, input logic e_r1, input logic e_err,
                               input logic e_ov);
        @(negedge clk);
        check_val({name, ".busy"},      32'(busy),      32'(e_busy));
        check_val({name, ".sel"},       32'(sel),       32'(e_sel));
        check_val({name, ".in0_ready"}, 32'(in0_ready), 32'(e_r0));
        check_val({name, ".in1_ready"}, 32'(in1_ready), 32'(e_r1));
        check_val({name, ".err"},       32'(err),       32'(e_err));
        check_val({name, ".out_valid"}, 32'(out_valid), 32'(e_ov));
        @(posedge clk);
        #1;
    endtask

    task automatic drive_packet(input bit port, input logic [7:0] base, input int n);
        logic [7:0] d;
        logic       l;
        bit         hs;
        int         waited;
        d = base;
        for (int i = 0; i < n; i++) begin
            l = (i == n - 1);
            if (port) begin
                in1_valid = 1'b1; in1_data = d; in1_last = l;
            end else begin
                in0_valid = 1'b1; in0_data = d; in0_last = l;
            end
            hs = 1'b0;
            waited = 0;
            while (!hs && waited < 100) begin
                @(negedge clk);
                hs = port ? (in1_valid && in1_ready) : (in0_valid && in0_ready);
                @(posedge clk);
                #1;
                waited++;
            end
            if (!hs) begin
                total++;
                bad++;
                $display("[TB] FAIL handshake_timeout: port=%0d beat=%0h got=no_ready expected=ready", port, d);
            end
            d = d + 8'd1;
        end
        if (port) begin
            in1_valid = 1'b0; in1_last = 1'b0;
        end else begin
            in0_valid = 1'b0; in0_last = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_val("reset.out_data", 32'(out_data), 32'h0);
        check_val("reset.out_last", 32'(out_last), 32'h0);
        checkOutput("reset", 0, 0, 0, 0, 0, 0);

        // Contention straight out of reset: in0 wins first, then strict alternation.
        push(8'hA1, 0); push(8'hA2, 1); push(8'hB1, 0); push(8'hB2, 1);
        push(8'hA3, 0); push(8'hA4, 1); push(8'hB3, 0); push(8'hB4, 1);
        rst_n = 1'b1;
        fork
            begin
                drive_packet(0, 8'hA1, 2);
                drive_packet(0, 8'hA3, 2);
            end
            begin
                drive_packet(1, 8'hB1, 2);
                drive_packet(1, 8'hB3, 2);
            end
        join
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_val("contention_drain", 32'(sb.size()), 32'd0);

        // Single requester, 3-beat packet; sel still holds 1 from the last in1 grant.
        push(8'h11, 0); push(8'h22, 0); push(8'h33, 1);
        applyStimulus(1, 8'h11, 0, 0, 8'h00, 0, 1);
        checkOutput("single_c0", 0, 1, 0, 0, 0, 0);
        checkOutput("single_c1", 1, 0, 1, 0, 0, 0);
        applyStimulus(1, 8'h22, 0, 0, 8'h00, 0, 1);
        checkOutput("single_c2", 1, 0, 1, 0, 0, 1);
        applyStimulus(1, 8'h33, 1, 0, 8'h00, 0, 1);
        checkOutput("single_c3", 1, 0, 1, 0, 0, 1);
        applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);
        checkOutput("single_c4", 0, 0, 0, 0, 0, 1);
        checkOutput("single_c5", 0, 0, 0, 0, 0, 0);

        // Backpressure: three stalled cycles while D2 sits in the output register.
        push(8'hD1, 0); push(8'hD2, 0); push(8'hD3, 0); push(8'hD4, 1);
        applyStimulus(1, 8'hD1, 0, 0, 8'h00, 0, 1);
        checkOutput("bp_c0", 0, 0, 0, 0, 0, 0);
        checkOutput("bp_c1", 1, 0, 1, 0, 0, 0);
        applyStimulus(1, 8'hD2, 0, 0, 8'h00, 0, 1);
        checkOutput("bp_c2", 1, 0, 1, 0, 0, 1);
        applyStimulus(1, 8'hD3, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_stall", 1, 0, 0, 0, 0, 1);
            check_val("bp_hold", 32'(out_data), 32'hD2);
        end
        applyStimulus(1, 8'hD3, 0, 0, 8'h00, 0, 1);
        checkOutput("bp_c6", 1, 0, 1, 0, 0, 1);
        applyStimulus(1, 8'hD4, 1, 0, 8'h00, 0, 1);
        checkOutput("bp_c7", 1, 0, 1, 0, 0, 1);
        applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);
        checkOutput("bp_c8", 0, 0, 0, 0, 0, 1);
        checkOutput("bp_c9", 0, 0, 0, 0, 0, 0);

        // Truncation: six beats with no last; beat 4 is forced last, then a fresh grant.
        push(8'hC1, 0); push(8'hC2, 0); push(8'hC3, 0); push(8'hC4, 1);
        push(8'hC5, 0); push(8'hC6, 0);
        applyStimulus(0, 8'h00, 0, 1, 8'hC1, 0, 1);
        checkOutput("trunc_c0", 0, 0, 0, 0, 0, 0);
        checkOutput("trunc_c1", 1, 1, 0, 1, 0, 0);
        applyStimulus(0, 8'h00, 0, 1, 8'hC2, 0, 1);
        checkOutput("trunc_c2", 1, 1, 0, 1, 0, 1);
        applyStimulus(0, 8'h00, 0, 1, 8'hC3, 0, 1);
        checkOutput("trunc_c3", 1, 1, 0, 1, 0, 1);
        applyStimulus(0, 8'h00, 0, 1, 8'hC4, 0, 1);
        checkOutput("trunc_c4", 1, 1, 0, 1, 0, 1);
        applyStimulus(0, 8'h00, 0, 1, 8'hC5, 0, 1);
        checkOutput("trunc_c5", 0, 1, 0, 0, 1, 1);
        checkOutput("trunc_c6", 1, 1, 0, 1, 0, 0);
        applyStimulus(0, 8'h00, 0, 1, 8'hC6, 0, 1);
        checkOutput("trunc_c7", 1, 1, 0, 1, 0, 1);
        applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);
        checkOutput("trunc_c8", 1, 1, 0, 1, 0, 1);
        checkOutput("trunc_c9", 1, 1, 0, 1, 0, 0);

        // Reset while locked on in1 with no packet end in sight.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("rst_lock", 0, 0, 0, 0, 0, 0);

        // Reset during beat 2 of 4, then a tie must go to in0 again.
        push(8'hE1, 0); push(8'hF1, 1); push(8'h71, 1);
        applyStimulus(1, 8'hE1, 0, 0, 8'h00, 0, 1);
        checkOutput("rmid_c0", 0, 0, 0, 0, 0, 0);
        checkOutput("rmid_c1", 1, 0, 1, 0, 0, 0);
        applyStimulus(1, 8'hE2, 0, 0, 8'h00, 0, 1);
        rst_n = 1'b0;
        checkOutput("rmid_c2", 1, 0, 1, 0, 0, 1);
        rst_n = 1'b1;
        applyStimulus(1, 8'hF1, 1, 1, 8'h71, 1, 1);
        checkOutput("rmid_c3", 0, 0, 0, 0, 0, 0);
        checkOutput("rmid_c4", 1, 0, 1, 0, 0, 0);
        applyStimulus(0, 8'h00, 0, 1, 8'h71, 1, 1);
        checkOutput("rmid_c5", 0, 0, 0, 0, 0, 1);
        checkOutput("rmid_c6", 1, 1, 0, 1, 0, 0);
        applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);
        checkOutput("rmid_c7", 0, 1, 0, 0, 0, 1);
        checkOutput("rmid_c8", 0, 1, 0, 0, 0, 0);

        check_val("final_drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
